// File: rtl/hsi_style_ctrl_if.sv
// rtl/hsi_style_ctrl_if.sv - key/sync/enable inputs and committed HSI style outputs
interface hsi_style_ctrl_if;
  logic       iKEY_NEXT;
  logic       iKEY_PREV;
  logic [1:0] iSEL;
  logic [2:0] iEN;
  logic       iVS;
  logic       oSW_H;
  logic       oSW_S;
  logic       oSW_I;
  logic [2:0] oLVL_H;
  logic [2:0] oLVL_S;
  logic [2:0] oLVL_I;
  logic       oPEND;

  modport master (
    output iKEY_NEXT, iKEY_PREV, iSEL, iEN, iVS,
    input  oSW_H, oSW_S, oSW_I, oLVL_H, oLVL_S, oLVL_I, oPEND
  );

  modport slave (
    input  iKEY_NEXT, iKEY_PREV, iSEL, iEN, iVS,
    output oSW_H, oSW_S, oSW_I, oLVL_H, oLVL_S, oLVL_I, oPEND
  );
endinterface

// File: rtl/hsi_style_ctrl.sv
// rtl/hsi_style_ctrl.sv - debounced key stepping of HSI levels, committed on vsync
// Optional demo auto-stepping while iSEL=11 is enabled by defining HSI_AUTO_CYCLE_EN.
module hsi_style_ctrl #(
  parameter int DB_CYCLES   = 250000,
  parameter int AUTO_FRAMES = 30
) (
  input logic              iCLK,
  input logic              iRST,
  hsi_style_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [2:0]    LVL_RST  = 3'b011;

  logic [1:0] next_sy;
  logic [1:0] prev_sy;
  logic [1:0] vs_sy;
  logic [2:0] en_sy1;
  logic [2:0] en_sy2;
  logic       vs_d;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      next_sy <= '0;
      prev_sy <= '0;
      vs_sy   <= '0;
      en_sy1  <= '0;
      en_sy2  <= '0;
      vs_d    <= 1'b0;
    end else begin
      next_sy <= {next_sy[0], bus.iKEY_NEXT};
      prev_sy <= {prev_sy[0], bus.iKEY_PREV};
      vs_sy   <= {vs_sy[0], bus.iVS};
      en_sy1  <= bus.iEN;
      en_sy2  <= en_sy1;
      vs_d    <= vs_sy[1];
    end
  end

  logic key_next;
  logic key_prev;
  logic vs_rise;
  logic sel_none;

  assign key_next = next_sy[1];
  assign key_prev = prev_sy[1];
  assign vs_rise  = vs_sy[1] & ~vs_d;
  assign sel_none = (bus.iSEL == 2'b11);

  logic [1:0]    state;
  logic [CW-1:0] db_cnt;
  logic          key_dir;
  logic          key_hit;
  logic          step_evt;

  // The press is only held as valid while the latched key is the sole key down.
  assign key_hit  = key_dir ? (key_next & ~key_prev) : (key_prev & ~key_next);
  assign step_evt = (state == ST_PRESS_DB) && key_hit && (db_cnt == CNT_LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ST_IDLE;
      db_cnt  <= '0;
      key_dir <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_next ^ key_prev) begin
            state   <= ST_PRESS_DB;
            db_cnt  <= '0;
            key_dir <= key_next;
          end
        end
        ST_PRESS_DB: begin
          if (!key_hit) begin
            state <= ST_IDLE;
          end else if (db_cnt == CNT_LAST) begin
            state <= ST_HELD;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        ST_HELD: begin
          if (!key_next && !key_prev) begin
            state  <= ST_REL_DB;
            db_cnt <= '0;
          end
        end
        ST_REL_DB: begin
          if (key_next || key_prev) begin
            state <= ST_HELD;
          end else if (db_cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic auto_step;

`ifdef HSI_AUTO_CYCLE_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  logic [FW-1:0] frame_cnt;

  assign auto_step = vs_rise && sel_none && (frame_cnt == FW'(AUTO_FRAMES - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      frame_cnt <= '0;
    end else if (!sel_none) begin
      frame_cnt <= '0;
    end else if (vs_rise) begin
      frame_cnt <= auto_step ? '0 : frame_cnt + FW'(1);
    end
  end
`else
  assign auto_step = 1'b0;
`endif

  // Index 0=H, 1=S, 2=I for levels; enables keep the {H,S,I} bit order of iEN.
  logic [2:0][2:0] stg_lvl;
  logic [2:0][2:0] com_lvl;
  logic [2:0][2:0] lvl_nxt;
  logic [2:0][2:0] com_lvl_nxt;
  logic [2:0]      stg_en;
  logic [2:0]      com_en;
  logic [2:0]      com_en_nxt;
  logic            pend;

  always_comb begin
    lvl_nxt = stg_lvl;
    if (step_evt && !sel_none) begin
      if (key_dir && (stg_lvl[bus.iSEL] != 3'd7)) begin
        lvl_nxt[bus.iSEL] = stg_lvl[bus.iSEL] + 3'd1;
      end else if (!key_dir && (stg_lvl[bus.iSEL] != 3'd0)) begin
        lvl_nxt[bus.iSEL] = stg_lvl[bus.iSEL] - 3'd1;
      end
    end
    if (auto_step) begin
      for (int c = 0; c < 3; c++) begin
        lvl_nxt[c] = stg_lvl[c] + 3'd1;
      end
    end
  end

  // Commit copies the pre-event staged set, so a same-cycle step stays pending.
  assign com_lvl_nxt = vs_rise ? stg_lvl : com_lvl;
  assign com_en_nxt  = vs_rise ? stg_en  : com_en;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stg_lvl <= {LVL_RST, LVL_RST, LVL_RST};
      com_lvl <= {LVL_RST, LVL_RST, LVL_RST};
      stg_en  <= '0;
      com_en  <= '0;
      pend    <= 1'b0;
    end else begin
      stg_lvl <= lvl_nxt;
      stg_en  <= en_sy2;
      com_lvl <= com_lvl_nxt;
      com_en  <= com_en_nxt;
      pend    <= (lvl_nxt != com_lvl_nxt) || (en_sy2 != com_en_nxt);
    end
  end

  assign bus.oSW_H  = com_en[2];
  assign bus.oSW_S  = com_en[1];
  assign bus.oSW_I  = com_en[0];
  assign bus.oLVL_H = com_lvl[0];
  assign bus.oLVL_S = com_lvl[1];
  assign bus.oLVL_I = com_lvl[2];
  assign bus.oPEND  = pend;

endmodule

// File: tb/tb_hsi_style_ctrl.sv
// tb/tb_hsi_style_ctrl.sv - scoreboard bench for hsi_style_ctrl with a level-set reference model
module tb_hsi_style_ctrl;
  localparam int DB = 4;
  localparam int AF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hsi_style_ctrl_if hif ();

  hsi_style_ctrl #(.DB_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (hif)
  );

  typedef struct packed {
    logic [2:0] en;
    logic [2:0] h;
    logic [2:0] s;
    logic [2:0] i;
    logic       pend;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         m_stg[3];
  int         m_com[3];
  logic [2:0] m_stg_en;
  logic [2:0] m_com_en;
  int         auto_cnt;

  function automatic logic pend_model();
    logic p;
    p = (m_stg_en != m_com_en);
    for (int c = 0; c < 3; c++) if (m_stg[c] != m_com[c]) p = 1'b1;
    return p;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      m_stg[c] = 3;
      m_com[c] = 3;
    end
    m_stg_en = hif.iEN;
    m_com_en = 3'b000;
    auto_cnt = 0;
  endfunction

  function automatic void step_model(input logic [1:0] sel, input bit nxt);
    if (sel == 2'b11) return;
    if (nxt) m_stg[sel] = (m_stg[sel] == 7) ? 7 : m_stg[sel] + 1;
    else     m_stg[sel] = (m_stg[sel] == 0) ? 0 : m_stg[sel] - 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sel(input logic [1:0] s);
    hif.iSEL = s;
    if (s != 2'b11) auto_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hif.iKEY_NEXT = 1'b0;
    hif.iKEY_PREV = 1'b0;
    hif.iVS = 1'b0;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(4);
  endtask

  // Commit snapshot, then any same-edge step or auto step, then expected pending flag.
  task automatic commit_model(input bit evt, input bit evt_next);
    exp_t e;
    m_com = m_stg;
    m_com_en = m_stg_en;
    if (evt) step_model(hif.iSEL, evt_next);
`ifdef HSI_AUTO_CYCLE_EN
    if (hif.iSEL == 2'b11) begin
      auto_cnt++;
      if (auto_cnt == AF) begin
        auto_cnt = 0;
        for (int c = 0; c < 3; c++) m_stg[c] = (m_stg[c] + 1) % 8;
      end
    end
`endif
    e.en = m_com_en;
    e.h = 3'(m_com[0]);
    e.s = 3'(m_com[1]);
    e.i = 3'(m_com[2]);
    e.pend = pend_model();
    sb_q.push_back(e);
  endtask

  task automatic vsync(input logic [2:0] en);
    hif.iEN = en;
    m_stg_en = en;
    tick(4);
    hif.iVS = 1'b1;
    commit_model(1'b0, 1'b0);
    tick(3);
    hif.iVS = 1'b0;
    tick(6);
  endtask

  task automatic press(input bit nxt, input int hold);
    if (nxt) hif.iKEY_NEXT = 1'b1;
    else     hif.iKEY_PREV = 1'b1;
    tick(hold);
    hif.iKEY_NEXT = 1'b0;
    hif.iKEY_PREV = 1'b0;
    tick(DB + 8);
    if (hold > DB) step_model(hif.iSEL, nxt);
  endtask

  task automatic check_pend(input string name);
    checks++;
    if (hif.oPEND !== pend_model()) begin
      failures++;
      $display("FAIL %s oPEND got=%b exp=%b", name, hif.oPEND, pend_model());
    end
  endtask

  task automatic check_committed(input string name);
    logic [11:0] act, exp;
    act = {hif.oSW_H, hif.oSW_S, hif.oSW_I, hif.oLVL_H, hif.oLVL_S, hif.oLVL_I};
    exp = {m_com_en, 3'(m_com[0]), 3'(m_com[1]), 3'(m_com[2])};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s outputs got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: a raw vsync rise is committed three clock edges after it is sampled.
  initial begin
    logic prev_vs;
    exp_t e;
    exp_t a;
    prev_vs = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst && hif.iVS && !prev_vs) begin
        repeat (2) @(posedge clk);
        #1;
        a = {hif.oSW_H, hif.oSW_S, hif.oSW_I, hif.oLVL_H, hif.oLVL_S, hif.oLVL_I, hif.oPEND};
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL commit_no_expect got=%h exp=none", a);
        end else begin
          e = sb_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL commit got=%h exp=%h (en,h,s,i,pend)", a, e);
          end
        end
      end
      prev_vs = hif.iVS;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit nxt;
    int hold;
    hif.iKEY_NEXT = 1'b0;
    hif.iKEY_PREV = 1'b0;
    hif.iSEL = 2'b00;
    hif.iEN = 3'b000;
    hif.iVS = 1'b0;
    model_reset();
    do_reset();

    check_committed("reset_outputs");
    check_pend("reset_pend");
    vsync(3'b000);

    set_sel(2'b01);
    press(1'b1, 20);
    check_pend("press_pending");
    check_committed("press_before_vsync");
    vsync(3'b000);
    check_pend("press_after_commit");

    for (int k = 0; k < 5; k++) begin
      hif.iKEY_NEXT = 1'b1;
      tick(1);
      hif.iKEY_NEXT = 1'b0;
      tick(1);
    end
    tick(DB + 8);
    check_pend("bounce_no_event");
    vsync(3'b000);

    set_sel(2'b00);
    for (int k = 0; k < 6; k++) press(1'b1, 12);
    vsync(3'b000);
    press(1'b0, 12);
    vsync(3'b000);

    hif.iKEY_NEXT = 1'b1;
    hif.iKEY_PREV = 1'b1;
    tick(15);
    hif.iKEY_NEXT = 1'b0;
    hif.iKEY_PREV = 1'b0;
    tick(DB + 8);
    check_pend("both_keys_no_event");
    vsync(3'b000);

    set_sel(2'b10);
    hif.iKEY_NEXT = 1'b1;
    tick(5);
    rst = 1'b1;
    hif.iKEY_NEXT = 1'b0;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(DB + 8);
    check_committed("reset_mid_press");
    check_pend("reset_mid_press_pend");
    vsync(3'b000);

    set_sel(2'b01);
    vsync(3'b101);
    nxt = (m_stg[1] != 7);
    if (nxt) hif.iKEY_NEXT = 1'b1;
    else     hif.iKEY_PREV = 1'b1;
    tick(DB);
    hif.iVS = 1'b1;
    commit_model(1'b1, nxt);
    tick(3);
    hif.iVS = 1'b0;
    tick(3);
    hif.iKEY_NEXT = 1'b0;
    hif.iKEY_PREV = 1'b0;
    tick(DB + 8);
    check_pend("same_cycle_pending");
    vsync(3'b101);

    for (int k = 0; k < 16; k++) begin
      set_sel(2'($urandom_range(0, 3)));
      nxt = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB + 2, 20);
      press(nxt, hold);
      check_pend("random_press_pend");
      if ((k % 4) == 3) vsync(3'($urandom_range(0, 7)));
    end

`ifdef HSI_AUTO_CYCLE_EN
    set_sel(2'b11);
    do_reset();
    for (int k = 0; k < 12; k++) vsync(3'b111);
    set_sel(2'b00);
    vsync(3'b111);
`endif

    tick(10);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hsi_style_ctrl.md
HSI_STYLE_CTRL -- requirements
Module: hsi_style_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 250000, giving the debounce stability window in clocks (minimum 2).
REQ-002 The block SHALL have parameter AUTO_FRAMES, default 30, giving the frames per auto step (used only under REQ-024).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port iCLK, input, 1 bit: pixel clock.
REQ-005 Port iRST, input, 1 bit: asynchronous reset, active-high.
REQ-006 Port iKEY_NEXT, input, 1 bit: raw button, active-high, asynchronous to iCLK.
REQ-007 Port iKEY_PREV, input, 1 bit: raw button, active-high, asynchronous to iCLK.
REQ-008 Port iSEL, input, 2 bits: channel the keys act on (00=H, 01=S, 10=I, 11=none).
REQ-009 Port iEN, input, 3 bits: channel enables {H,S,I}, asynchronous to iCLK.
REQ-010 Port iVS, input, 1 bit: vertical sync, active-high, asynchronous to iCLK.
REQ-011 Ports oSW_H, oSW_S and oSW_I, output, 1 bit each: committed channel enables to the HSI datapath.
REQ-012 Ports oLVL_H, oLVL_S and oLVL_I, output, 3 bits each: committed level codes, driven as {swX1,swX2,swX3}.
REQ-013 Port oPEND, output, 1 bit: staged settings differ from committed settings.

Function
REQ-014 The block SHALL synchronise iKEY_NEXT, iKEY_PREV, iEN and iVS through 2-flop synchronisers before any use.
REQ-015 The block SHALL run a key FSM with states IDLE, PRESS_DB, HELD and REL_DB.
- IDLE: exactly one synced key high -> PRESS_DB and clear the counter; both high -> stay in IDLE.
- PRESS_DB: that key stays high for DB_CYCLES consecutive clocks -> HELD and issue one step event in the transition cycle; any bounce -> IDLE.
- HELD: both keys low -> REL_DB.
- REL_DB: both keys low for DB_CYCLES clocks -> IDLE; any key high -> HELD.
REQ-016 The block SHALL issue exactly one step event per press, with no auto-repeat while the key is held.
REQ-017 A step event SHALL update the staged level of the channel selected by iSEL, sampled in the event cycle.
- NEXT adds 1 and PREV subtracts 1.
- The level saturates at 7 and at 0, with no wrap.
- iSEL=11 discards the event.
REQ-018 The staged enables SHALL follow the synced iEN every clock.
REQ-019 On each rising edge of the synced iVS, the block SHALL copy all staged enables and levels to the committed outputs in that cycle, so outputs change 1 clock after the edge is detected.
REQ-020 Committed outputs SHALL NOT change at any time other than the commit of REQ-019 or reset.
REQ-021 When a step event and a vsync edge occur in the same cycle, the commit SHALL take the pre-event staged values; the event then updates the staged value, oPEND stays 1, and the change commits at the next edge.
REQ-022 oPEND SHALL be a registered comparison of the staged and committed sets and SHALL be 0 immediately after a commit with no same-cycle event.

Reset
REQ-023 While iRST is high, the block SHALL immediately set:
- all synchronisers to 0;
- the FSM to IDLE and the counters to 0;
- staged and committed enables to 0;
- staged and committed levels to 3'b011;
- oPEND to 0.
A reset during PRESS_DB discards the pending press; after release of iRST the FSM waits in IDLE.

Configuration
REQ-024 The macro HSI_AUTO_CYCLE_EN SHALL control demo stepping:
- When defined: while iSEL=11, every AUTO_FRAMES vsync edges the staged levels of all three channels increment, wrapping 7 to 0, and the frame counter resets to 0 when iSEL leaves 11.
- When undefined: none of the auto logic is synthesised and iSEL=11 only discards events.

Verification
REQ-025 The bench SHALL cover these scenarios with DB_CYCLES=4:
- Reset, then iVS edge -> all oSW_* = 0, all oLVL_* = 3, oPEND = 0.
- iSEL=01, clean NEXT press held 20 clocks -> a single increment; oLVL_S stays 3 until the next vsync edge, then becomes 4; oPEND goes 1 then 0.
- NEXT bounce of 1-clock pulses, each shorter than 4 clocks -> no event, oPEND stays 0.
- iSEL=00, 6 NEXT presses from level 3 -> oLVL_H = 7 after commit; a PREV press then gives 6.
- Both keys pressed together -> no event; iRST asserted mid-PRESS_DB -> no event after release.
- Event and vsync edge in the same cycle -> committed value is the old level and oPEND = 1; the next edge commits the new level.
- With HSI_AUTO_CYCLE_EN defined, AUTO_FRAMES=2, iSEL=11 -> levels step 3,4,5 every 2 frames and wrap 7 to 0.
